mem_access: RTL

Load/store stage between execute and write-back of the in-order RV32I core. Converts each execute-stage memory instruction into a single request on the memory controller's data port (`mm_*`), holds the pipeline until the controller acknowledges, then sign- or zero-extends load data and presents the result to write-back. Non-memory instructions pass through in one cycle.

---
 rtl/mem_access_if.sv | 21 ++
 rtl/mem_access.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mem_access_if.sv
// Data-port bundle between the load/store stage and the memory controller.
// The stage drives the request side (master); the controller answers (slave).
interface mem_access_if;
  logic        mm_e;
  logic [31:0] mm_a;
  logic [31:0] mm_n_i;
  logic        mm_wr;
  logic [1:0]  mm_cu;
  logic        mm_ok;
  logic [31:0] mm_n_o;

  modport master (
    output mm_e, mm_a, mm_n_i, mm_wr, mm_cu,
    input  mm_ok, mm_n_o
  );

  modport slave (
    input  mm_e, mm_a, mm_n_i, mm_wr, mm_cu,
    output mm_ok, mm_n_o
  );
endinterface

// File: rtl/mem_access.sv
// RV32I load/store stage: one controller request per memory op, then extend.
// Optional MEM_ALIGN_CHECK_EN traps misaligned H/W accesses without a request.
module mem_access (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [1:0]  ex_mem,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_sdata,
  input  logic [31:0] ex_res,
  input  logic [4:0]  ex_rd,
  output logic        stall_o,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        misalign,
  mem_access_if.master mm
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]  state;
  logic [2:0]  f3_q;
  logic [4:0]  rd_q;
  logic        e_q;
  logic [31:0] a_q;
  logic [31:0] ni_q;
  logic        wr_q;
  logic [1:0]  cu_q;
  logic        mis_q;

  logic        is_ld;
  logic        is_st;
  logic        is_mem;
  logic [1:0]  cu_req;
  logic        mis;
  logic [31:0] ld_data;

  assign is_ld  = (ex_mem == 2'b01);
  assign is_st  = (ex_mem == 2'b10);
  assign is_mem = is_ld | is_st;

  // Stores size on funct3[1:0] only; unknown load encodings fall to W.
  always_comb begin
    cu_req = 2'd3;
    if (is_st) begin
      unique case (ex_funct3[1:0])
        2'b00:   cu_req = 2'd0;
        2'b01:   cu_req = 2'd1;
        default: cu_req = 2'd3;
      endcase
    end else begin
      unique case (ex_funct3)
        3'b000, 3'b100: cu_req = 2'd0;
        3'b001, 3'b101: cu_req = 2'd1;
        default:        cu_req = 2'd3;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign mis = is_mem &&
    ((cu_req == 2'd1 && ex_addr[0]) ||
     (cu_req == 2'd3 && ex_addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  // Bytes above the access size come back stale, so mask or extend.
  always_comb begin
    ld_data = mm.mm_n_o;
    unique case (f3_q)
      3'b000: ld_data = {{24{mm.mm_n_o[7]}}, mm.mm_n_o[7:0]};
      3'b001: ld_data = {{16{mm.mm_n_o[15]}}, mm.mm_n_o[15:0]};
      3'b100: ld_data = {24'd0, mm.mm_n_o[7:0]};
      3'b101: ld_data = {16'd0, mm.mm_n_o[15:0]};
      default: ld_data = mm.mm_n_o;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      e_q      <= 1'b0;
      a_q      <= 32'd0;
      ni_q     <= 32'd0;
      wr_q     <= 1'b0;
      cu_q     <= 2'd0;
      mis_q    <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
    end else begin
      wb_valid <= 1'b0;
      mis_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem) begin
              wb_valid <= 1'b1;
              wb_rd    <= ex_rd;
              wb_data  <= ex_res;
            end else if (mis) begin
              wb_valid <= 1'b1;
              mis_q    <= 1'b1;
              wb_rd    <= 5'd0;
              wb_data  <= 32'd0;
            end else begin
              f3_q  <= ex_funct3;
              rd_q  <= ex_rd;
              a_q   <= ex_addr;
              ni_q  <= ex_sdata;
              wr_q  <= is_st;
              cu_q  <= cu_req;
              e_q   <= 1'b1;
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mm.mm_ok) begin
            e_q      <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= wr_q ? 5'd0 : rd_q;
            wb_data  <= wr_q ? 32'd0 : ld_data;
            state    <= DROP;
          end
        end
        // Wait for ok to clear so the next request is a clean 0->1 edge.
        DROP: begin
          if (!mm.mm_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign stall_o   = (state != IDLE);
  assign misalign  = mis_q;
  assign mm.mm_e   = e_q;
  assign mm.mm_a   = a_q;
  assign mm.mm_n_i = ni_q;
  assign mm.mm_wr  = wr_q;
  assign mm.mm_cu  = cu_q;

endmodule
